// File: rtl/engine_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : engine_arb_pkg
// Description : Shared types and constants for the engine stream arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package engine_arb_pkg;

    localparam int SRC_W       = 3;
    localparam int ABORT_CNT_W = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Round-robin successor; wraps explicitly so non-power-of-two counts work.
    function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] idx, input int num);
        if (idx == SRC_W'(num - 1)) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/engine_stream_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin pick: rotate requests to start at
//               the pointer, then take the lowest set bit.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import engine_arb_pkg::*;
#(
    parameter int NUM_IN = 4
)(
    input  logic [NUM_IN-1:0] req,
    input  logic [SRC_W-1:0]  ptr,
    output logic [SRC_W-1:0]  idx,
    output logic              any
);

    localparam logic [SRC_W:0] c_NUM = (SRC_W+1)'(NUM_IN);

    logic [NUM_IN-1:0] w_rot;
    logic [SRC_W-1:0]  w_off;
    logic [SRC_W:0]    w_sum;

    // Bit i of the rotated vector is request (ptr + i) mod NUM_IN.
    assign w_rot = NUM_IN'({req, req} >> ptr);

    always_comb begin
        w_off = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SRC_W'(i);
            end
        end
    end

    assign w_sum = {1'b0, ptr} + {1'b0, w_off};
    assign idx   = (w_sum >= c_NUM) ? SRC_W'(w_sum - c_NUM) : w_sum[SRC_W-1:0];
    assign any   = |req;

endmodule
`default_nettype wire

// File: rtl/engine_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : engine_stream_arbiter
// Description : Packet-granular round-robin arbiter with stall watchdog in
//               front of the vector engine input stream.
// Revision    : 1.0 - initial release
// ============================================================================
module engine_stream_arbiter
    import engine_arb_pkg::*;
#(
    parameter int NUM_IN  = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 4096
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] s_data,
    input  logic [NUM_IN-1:0]       s_last,
    input  logic [NUM_IN-1:0]       s_valid,
    output logic [NUM_IN-1:0]       s_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic                    m_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [SRC_W-1:0]        o_src,
    output logic                    o_busy,
    output logic                    o_abort,
    output logic [ABORT_CNT_W-1:0]  o_abort_cnt,
    input  logic                    i_cnt_clr
);

    localparam int c_STALL_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_STALL_MAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [c_STALL_W-1:0] c_STALL_LIMIT = c_STALL_W'(c_STALL_MAX);

    arb_state_e             r_state;
    logic [SRC_W-1:0]       r_grant;
    logic [SRC_W-1:0]       r_rr_ptr;
    logic [c_STALL_W-1:0]   r_stall_cnt;
    logic                   r_abort;
    logic [ABORT_CNT_W-1:0] r_abort_cnt;

    logic [SRC_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_granted;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_last;
    logic             w_sel_valid;
    logic             w_beat;
    logic             w_expire;

    rr_pick #(
        .NUM_IN (NUM_IN)
    ) u_pick (
        .req (s_valid),
        .ptr (r_rr_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    assign w_granted = (r_state == GRANT);

    // Zero-latency data path: the granted slice is muxed straight through.
    always_comb begin
        w_sel_data  = '0;
        w_sel_last  = 1'b0;
        w_sel_valid = 1'b0;
        s_ready     = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (r_grant == SRC_W'(i)) begin
                w_sel_data  = s_data[i*WIDTH +: WIDTH];
                w_sel_last  = s_last[i];
                w_sel_valid = s_valid[i];
                s_ready[i]  = w_granted & m_ready;
            end
        end
    end

    assign m_data  = w_granted ? w_sel_data : '0;
    assign m_last  = w_granted & w_sel_last;
    assign m_valid = w_granted & w_sel_valid;

    assign w_beat   = w_granted & w_sel_valid & m_ready;
    // A final beat landing on the expiry cycle wins over the abort.
    assign w_expire = (TIMEOUT != 0) && w_granted && !w_beat && (r_stall_cnt == c_STALL_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_stall_cnt <= '0;
            r_abort     <= 1'b0;
            r_abort_cnt <= '0;
        end else begin
            r_abort <= 1'b0;

            if (i_cnt_clr) begin
                r_abort_cnt <= '0;
            end else if (w_expire && (r_abort_cnt != {ABORT_CNT_W{1'b1}})) begin
                r_abort_cnt <= r_abort_cnt + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_grant     <= w_pick_idx;
                        r_stall_cnt <= '0;
                        r_state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_beat) begin
                        r_stall_cnt <= '0;
                        if (w_sel_last) begin
                            r_rr_ptr <= next_src(r_grant, NUM_IN);
                            r_state  <= IDLE;
                        end
                    end else if (w_expire) begin
                        r_abort     <= 1'b1;
                        r_stall_cnt <= '0;
                        r_rr_ptr    <= next_src(r_grant, NUM_IN);
                        r_state     <= IDLE;
                    end else begin
                        r_stall_cnt <= r_stall_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_src       = r_grant;
    assign o_busy      = w_granted;
    assign o_abort     = r_abort;
    assign o_abort_cnt = r_abort_cnt;

endmodule
`default_nettype wire

// File: tb/tb_engine_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_engine_stream_arbiter
// Description : Self-checking bench: vector table, directed corner sequences
//               and randomized traffic against a packet-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_engine_stream_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] s_data;
    logic [N-1:0]   s_last;
    logic [N-1:0]   s_valid;
    logic [N-1:0]   s_ready;
    logic [W-1:0]   m_data;
    logic           m_last;
    logic           m_valid;
    logic           m_ready;
    logic [2:0]     o_src;
    logic           o_busy;
    logic           o_abort;
    logic [15:0]    o_abort_cnt;
    logic           i_cnt_clr;

    engine_stream_arbiter #(
        .NUM_IN  (N),
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .o_src       (o_src),
        .o_busy      (o_busy),
        .o_abort     (o_abort),
        .o_abort_cnt (o_abort_cnt),
        .i_cnt_clr   (i_cnt_clr)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, name, act, exp, $time);
        end
    endtask

    // Packet-level reference: who owns the stream, where the next search starts,
    // how long the owner has been silent, and how many packets were cut off.
    int md_own, md_ptr, md_quiet, md_aborts, md_src;
    bit md_abort;

    task automatic model_reset();
        md_own = -1; md_ptr = 0; md_quiet = 0; md_aborts = 0; md_src = 0; md_abort = 0;
    endtask

    task automatic model_step();
        bit cut;
        cut = 0;
        if (md_own < 0) begin
            for (int k = 0; k < N; k++) begin
                if (s_valid[(md_ptr + k) % N]) begin
                    md_own   = (md_ptr + k) % N;
                    md_src   = md_own;
                    md_quiet = 0;
                    break;
                end
            end
        end else if (s_valid[md_own] && m_ready) begin
            md_quiet = 0;
            if (s_last[md_own]) begin
                md_ptr = (md_own + 1) % N;
                md_own = -1;
            end
        end else begin
            md_quiet++;
            if (TO > 0 && md_quiet >= TO) begin
                cut = 1;
                if (md_aborts < 65535) md_aborts++;
                md_ptr = (md_own + 1) % N;
                md_own = -1;
            end
        end
        if (i_cnt_clr) md_aborts = 0;
        md_abort = cut;
    endtask

    task automatic check_model();
        logic [N-1:0] er;
        logic [W-1:0] ed;
        logic         el, ev;
        er = '0; ed = '0; el = 1'b0; ev = 1'b0;
        if (md_own >= 0) begin
            ev = s_valid[md_own];
            el = s_last[md_own];
            ed = s_data[md_own*W +: W];
            if (m_ready) er[md_own] = 1'b1;
        end
        chk("m_valid", m_valid, ev);
        chk("m_last", m_last, el);
        chk("m_data", m_data, ed);
        chk("s_ready", s_ready, er);
        chk("o_busy", o_busy, md_own >= 0);
        if (md_own >= 0) chk("o_src", o_src, md_src);
        chk("o_abort", o_abort, md_abort);
        chk("o_abort_cnt", o_abort_cnt, md_aborts);
    endtask

    // Inputs change at posedge+1; outputs are compared at posedge+4.
    task automatic sample();
        #3;
        check_model();
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [31:0] d0, d1, d2, d3);
        s_data = {d3, d2, d1, d0};
    endtask

    function automatic logic [31:0] enc(input int s, input int b);
        return 32'hC0DE_0000 | 32'(s << 4) | 32'(b);
    endfunction

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        ready;
        logic [31:0] d2;
        logic        e_valid;
        logic        e_last;
        logic [31:0] e_data;
        logic [3:0]  e_ready;
        logic        e_busy;
        logic [2:0]  e_src;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] v, l, input logic r, input logic [31:0] d2,
                                input logic ev, el, input logic [31:0] ed, input logic [3:0] er,
                                input logic eb, input logic [2:0] es);
        vec_t t;
        t.valid = v; t.last = l; t.ready = r; t.d2 = d2;
        t.e_valid = ev; t.e_last = el; t.e_data = ed; t.e_ready = er; t.e_busy = eb; t.e_src = es;
        return t;
    endfunction

    vec_t tbl [15];
    int   bc  [N];
    int   at, prob;
    bit   seen;
    logic exp_v;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Single source 2, pointer check via sources 2/3, then a backpressured packet.
        tbl[0]  = mk(4'b0000, 4'b0000, 1, 32'hA0, 0, 0, 32'h0,         4'b0000, 0, 0);
        tbl[1]  = mk(4'b0100, 4'b0000, 1, 32'hA0, 0, 0, 32'h0,         4'b0000, 0, 0);
        tbl[2]  = mk(4'b0100, 4'b0000, 1, 32'hA0, 1, 0, 32'hA0,        4'b0100, 1, 2);
        tbl[3]  = mk(4'b0100, 4'b0000, 1, 32'hA1, 1, 0, 32'hA1,        4'b0100, 1, 2);
        tbl[4]  = mk(4'b0100, 4'b0000, 1, 32'hA2, 1, 0, 32'hA2,        4'b0100, 1, 2);
        tbl[5]  = mk(4'b0100, 4'b0000, 1, 32'hA3, 1, 0, 32'hA3,        4'b0100, 1, 2);
        tbl[6]  = mk(4'b0100, 4'b0100, 1, 32'hA4, 1, 1, 32'hA4,        4'b0100, 1, 2);
        tbl[7]  = mk(4'b1100, 4'b1000, 1, 32'hA9, 0, 0, 32'h0,         4'b0000, 0, 0);
        tbl[8]  = mk(4'b1100, 4'b1000, 1, 32'hA9, 1, 1, 32'hDEAD_0003, 4'b1000, 1, 3);
        tbl[9]  = mk(4'b1100, 4'b0000, 1, 32'hA5, 0, 0, 32'h0,         4'b0000, 0, 0);
        tbl[10] = mk(4'b1100, 4'b0000, 1, 32'hA5, 1, 0, 32'hA5,        4'b0100, 1, 2);
        tbl[11] = mk(4'b1100, 4'b0000, 0, 32'hA6, 1, 0, 32'hA6,        4'b0000, 1, 2);
        tbl[12] = mk(4'b1100, 4'b0000, 0, 32'hA6, 1, 0, 32'hA6,        4'b0000, 1, 2);
        tbl[13] = mk(4'b1100, 4'b0100, 1, 32'hA6, 1, 1, 32'hA6,        4'b0100, 1, 2);
        tbl[14] = mk(4'b0000, 4'b0000, 1, 32'hA0, 0, 0, 32'h0,         4'b0000, 0, 0);

        reset = 1'b1; s_valid = '0; s_last = '0; m_ready = 1'b0; i_cnt_clr = 1'b0; s_data = '0;
        model_reset();
        #2;
        phase = "reset";
        chk("m_valid", m_valid, 0);
        chk("m_last", m_last, 0);
        chk("m_data", m_data, 0);
        chk("s_ready", s_ready, 0);
        chk("o_busy", o_busy, 0);
        chk("o_src", o_src, 0);
        chk("o_abort", o_abort, 0);
        chk("o_abort_cnt", o_abort_cnt, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        phase = "table";
        for (int r = 0; r < 15; r++) begin
            s_valid = tbl[r].valid;
            s_last  = tbl[r].last;
            m_ready = tbl[r].ready;
            set_data(32'hDEAD_0000, 32'hDEAD_0001, tbl[r].d2, 32'hDEAD_0003);
            sample();
            chk($sformatf("row%0d_valid", r), m_valid, tbl[r].e_valid);
            chk($sformatf("row%0d_last", r), m_last, tbl[r].e_last);
            chk($sformatf("row%0d_data", r), m_data, tbl[r].e_data);
            chk($sformatf("row%0d_ready", r), s_ready, tbl[r].e_ready);
            chk($sformatf("row%0d_busy", r), o_busy, tbl[r].e_busy);
            if (tbl[r].e_busy) chk($sformatf("row%0d_src", r), o_src, tbl[r].e_src);
            advance();
        end

        phase = "async_reset";
        s_valid = 4'b0010; s_last = '0; m_ready = 1'b1;
        sample(); advance();
        sample();
        chk("pre_valid", m_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", o_busy, 0);
        reset = 1'b0;
        s_valid = '0;
        model_reset();
        #1;
        advance();

        // After reset all four contend with 3-beat packets: order 0,1,2,3,0.
        phase = "contention";
        for (int i = 0; i < N; i++) bc[i] = 0;
        s_valid = 4'b1111; m_ready = 1'b1;
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++) s_last[i] = (bc[i] == 2);
            set_data(enc(0, bc[0]), enc(1, bc[1]), enc(2, bc[2]), enc(3, bc[3]));
            sample();
            exp_v = (t != 0) && (((t - 1) % 4) < 3);
            chk($sformatf("t%0d_valid", t), m_valid, exp_v);
            if (exp_v) chk($sformatf("t%0d_data", t), m_data, enc(((t - 1) / 4) % 4, (t - 1) % 4));
            for (int i = 0; i < N; i++) if (s_ready[i]) bc[i] = (bc[i] + 1) % 3;
            advance();
        end

        phase = "watchdog";
        s_valid = 4'b0110; s_last = '0; m_ready = 1'b1;
        set_data(32'h1000, 32'h1001, 32'h1002, 32'h1003);
        sample(); advance();
        sample(); chk("wd_src", o_src, 1); advance();
        sample(); advance();
        s_valid = 4'b0100;
        at = -1;
        for (int c = 1; c <= 40; c++) begin
            sample();
            if (o_abort === 1'b1) begin
                at = c;
                break;
            end
            advance();
        end
        chk("wd_abort_cycle", at, 17);
        chk("wd_cnt", o_abort_cnt, 1);
        chk("wd_busy", o_busy, 0);
        advance();
        sample();
        chk("wd_pulse_end", o_abort, 0);
        chk("wd_next_busy", o_busy, 1);
        chk("wd_next_src", o_src, 2);

        phase = "late_beat";
        seen = 0;
        advance();
        for (int rep = 0; rep < 2; rep++) begin
            for (int c = 1; c <= 16; c++) begin
                s_valid = (c == 16) ? 4'b0100 : 4'b0000;
                s_last  = (rep == 1 && c == 16) ? 4'b0100 : 4'b0000;
                sample();
                if (o_abort) seen = 1;
                advance();
            end
        end
        s_valid = '0; s_last = '0;
        sample();
        if (o_abort) seen = 1;
        chk("late_no_abort", seen, 0);
        chk("late_idle", o_busy, 0);
        chk("late_cnt", o_abort_cnt, 1);

        phase = "clr";
        s_valid = 4'b1000;
        advance();
        sample(); advance();
        s_valid = '0;
        for (int c = 1; c <= 15; c++) begin
            sample(); advance();
        end
        i_cnt_clr = 1'b1;
        sample(); advance();
        i_cnt_clr = 1'b0;
        sample();
        chk("clr_abort", o_abort, 1);
        chk("clr_cnt", o_abort_cnt, 0);
        advance();

        phase = "random";
        for (int cyc = 0; cyc < 1500; cyc++) begin
            case ((cyc / 100) % 3)
                0:       prob = 90;
                1:       prob = 50;
                default: prob = 5;
            endcase
            for (int i = 0; i < N; i++) begin
                s_valid[i] = ($urandom_range(99) < prob);
                s_last[i]  = ($urandom_range(99) < 30);
            end
            m_ready   = ($urandom_range(99) < 70);
            i_cnt_clr = ($urandom_range(99) < 1);
            set_data($urandom, $urandom, $urandom, $urandom);
            sample();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/engine_stream_arbiter.md
# engine_stream_arbiter

Packet-granular round-robin arbiter that shares the 32-bit input stream of a vector engine top (its t0 data/last/valid/ready port) between NUM_IN upstream requesters. Sits directly in front of the engine's input buffer. Holds a grant for a whole packet, delimited by `last`, so packets from different sources never interleave. Provides a stall watchdog and CSR-readable status (current source, abort count) so engine firmware can see which source fed it and detect hung producers.

## Interface
Parameters:
- NUM_IN, 4: number of requesters, 2..8
- WIDTH, 32: data width
- TIMEOUT, 4096: max consecutive cycles inside a granted packet with no input beat before abort; 0 disables the watchdog

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high; all state clears immediately on assertion
- s_data  in  NUM_IN*WIDTH  requester data, slice i = [i*WIDTH +: WIDTH]
- s_last  in  NUM_IN  end-of-packet per requester
- s_valid  in  NUM_IN  per-requester valid
- s_ready  out  NUM_IN  per-requester ready; one-hot or zero
- m_data  out  WIDTH  to engine t0_data
- m_last  out  1  to engine t0_last
- m_valid  out  1  to engine t0_valid
- m_ready  in  1  from engine t0_ready
- o_src  out  3  index of the granted requester; valid while o_busy
- o_busy  out  1  a packet grant is held
- o_abort  out  1  one-cycle pulse when the watchdog releases a grant
- o_abort_cnt  out  16  saturating count of aborts
- i_cnt_clr  in  1  synchronous clear of o_abort_cnt

## Operation
- FSM states: IDLE, GRANT.
- **IDLE**
  - m_valid=0; s_ready=0.
  - If any s_valid is high: select the first requester with s_valid high, searching from rr_ptr upward with wrap-around.
  - Register the selection into grant; go to GRANT.
- **GRANT** (grant = g)
  - m_data/m_last/m_valid = slice g, combinational mux.
  - s_ready[g] = m_ready; every other s_ready = 0.
  - Beat = s_valid[g] && m_ready.
  - Beat with s_last[g]=1: rr_ptr <= (g+1) mod NUM_IN; go to IDLE.
- **Watchdog**
  - stall_cnt clears on every beat and on entering GRANT; otherwise it increments while in GRANT.
  - When stall_cnt reaches TIMEOUT-1 with no beat in that cycle: pulse o_abort; o_abort_cnt += 1, saturating at 0xFFFF; rr_ptr <= g+1; go to IDLE.
  - The engine receives no synthetic `last`; firmware handles truncated packets using the abort count.
- A beat with `last` in the same cycle as timeout expiry counts as a normal end: no abort.
- i_cnt_clr takes priority over a simultaneous increment; the counter reads 0 next cycle.
- Dropping s_valid mid-packet is legal; the grant is held, subject to the watchdog.
- NUM_IN not a power of two: rr_ptr wraps at NUM_IN explicitly, never by overflow.
- Reset mid-packet: FSM returns to IDLE and the partial packet is abandoned. Downstream recovery is the engine's concern.

## Timing
- Reset values:
  - m_valid=0, m_last=0, m_data=0 (mux output gated to 0 in IDLE)
  - s_ready=0, o_busy=0, o_src=0, o_abort=0, o_abort_cnt=0
  - rr_ptr=0, FSM in IDLE
- Arbitration latency: s_valid rising in IDLE leads to m_valid, o_busy and o_src valid on the next cycle.
- Throughput: one beat per cycle within a packet.
- Packet boundaries: exactly one idle (bubble) cycle between packets.
- Data path: zero registers; m_ready to s_ready is combinational. The engine top's input buffer absorbs its delayed-ready behaviour, so this block needs no extra stage.
- o_abort: asserted the cycle after expiry, together with the IDLE transition.

## Structure
- Shared package `engine_arb_pkg`:
  - state enum (IDLE, GRANT)
  - SRC_W = 3
  - ABORT_CNT_W = 16
- Sub-module `rr_pick`:
  - inputs: NUM_IN-bit request vector, rr_ptr
  - outputs: index and any-request flag
  - purely combinational, rotate-then-priority-encode
- The top holds the FSM, grant/pointer registers, watchdog and counter.

## Test plan
- **Single source:** NUM_IN=4; requester 2 sends a 5-beat packet 0xA0..0xA4 with last on beat 5 → m_data sequence identical, o_src=2, m_valid starts 1 cycle after s_valid, rr_ptr=3 afterward.
- **Contention:** all four valid continuously with 3-beat packets → grant order 0,1,2,3,0; one bubble between packets; no interleaved beats.
- **Backpressure:** m_ready toggles 1,0,0,1 during a packet → s_ready[g] mirrors m_ready; non-granted s_ready stays 0; no beat lost or duplicated.
- **Watchdog:**
  - TIMEOUT=16: source 1 stalls mid-packet → o_abort pulses once 16 cycles after the last beat; o_abort_cnt=1; next grant goes to source 2 if pending.
  - Beat arriving at cycle 15 → no abort.
- **Counter clear:** i_cnt_clr asserted in the same cycle as an abort → o_abort_cnt=0.
- **Async reset:** assert reset asynchronously mid-packet, between clock edges → m_valid, s_ready and o_busy go to 0 before the next edge; after release the first grant is to the lowest valid index ≥ 0.
